// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - button pins in, debounced levels/pulses/count out
interface button_debounce_if #(
  parameter int N_CH = 8
);
  logic [N_CH-1:0] btn_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic            any_press_o;
  logic [7:0]      press_cnt_o;

  // user side: drives the raw pins, consumes the clean view
  modport master (
    output btn_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  any_press_o,
    input  press_cnt_o
  );

  // debouncer side
  modport slave (
    input  btn_i,
    output level_o,
    output press_o,
    output release_o,
    output any_press_o,
    output press_cnt_o
  );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - N_CH button synchroniser, tick-based debouncer, press/release pulses and press counter
module button_debounce #(
  parameter int N_CH         = 8,
  parameter int TICK_DIV     = 25_000,
  parameter int STABLE_TICKS = 10,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  button_debounce_if.slave  bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(STABLE_TICKS + 1);

  // pin level of a released button; the synchroniser starts here so reset looks idle
  localparam logic [N_CH-1:0] IDLE_PIN  = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0]   DCNT_LAST = DW'(STABLE_TICKS - 1);

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic [N_CH-1:0] raw_p;

  logic [TW-1:0]   tick_cnt_q;
  logic [TW-1:0]   tick_cnt_d;
  logic            tick;

  logic [DW-1:0]   dcnt_q [N_CH];
  logic [DW-1:0]   dcnt_d [N_CH];
  logic [N_CH-1:0] level_q;
  logic [N_CH-1:0] level_d;
  logic [N_CH-1:0] press_q;
  logic [N_CH-1:0] press_d;
  logic [N_CH-1:0] release_q;
  logic [N_CH-1:0] release_d;

  logic [7:0]      press_cnt_q;
  logic [7:0]      press_cnt_d;
  logic [7:0]      press_pop;

  // 2-FF synchroniser on the asynchronous pins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
    end else begin
      sync1_q <= bus.btn_i;
      sync2_q <= sync1_q;
    end
  end

  // normalise polarity so 1 always means pressed
  assign raw_p = sync2_q ^ IDLE_PIN;

  // shared prescaler: tick fires on the last count of each period
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // tick counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // per-channel qualification: any agreement restarts, a full run of ticks accepts
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (raw_p[i] == level_q[i]) begin
        dcnt_d[i] = '0;
      end else if (tick) begin
        if (dcnt_q[i] == DCNT_LAST) begin
          level_d[i]   = raw_p[i];
          dcnt_d[i]    = '0;
          press_d[i]   = raw_p[i];
          release_d[i] = ~raw_p[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // debounce state and edge pulses; pulses land with the new level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        dcnt_q[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // popcount of this cycle's press pulses feeds the counter one cycle later
  always_comb begin
    press_pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      press_pop = press_pop + 8'(press_q[i]);
    end
    press_cnt_d = press_cnt_q + press_pop;
  end

  // wrapping press counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      press_cnt_q <= '0;
    end else begin
      press_cnt_q <= press_cnt_d;
    end
  end

  assign bus.level_o     = level_q;
  assign bus.press_o     = press_q;
  assign bus.release_o   = release_q;
  assign bus.any_press_o = |press_q;
  assign bus.press_cnt_o = press_cnt_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  button_debounce_if #(.N_CH(8)) bus ();

  button_debounce #(
    .N_CH(8),
    .TICK_DIV(4),
    .STABLE_TICKS(3),
    .ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // steps until a pulse on a masked channel; n = steps taken, -1 on timeout
  task automatic wait_evt(input bit rel, input logic [7:0] mask, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit && n < 0; i++) begin
      step();
      if (((rel ? bus.release_o : bus.press_o) & mask) != 8'h00) n = i;
    end
  endtask

  int  n;
  bit  flag;
  int  extra;
  int  misses;

  initial begin
    rst        = 1'b1;
    bus.btn_i  = 8'hFF;

    // 1. idle
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_state", {bus.level_o, bus.press_o, bus.release_o, 7'd0, bus.any_press_o, bus.press_cnt_o}, 32'h0);
    end
    rst = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if ({bus.level_o, bus.press_o, bus.release_o, bus.press_cnt_o} != 32'h0) flag = 1'b1;
    end
    check("idle_quiet", flag, 0);

    // 2. single press / release on ch0
    bus.btn_i[0] = 1'b0;
    wait_evt(0, 8'h01, 14, n);
    check("s2_press_lat", (n >= 11 && n <= 14), 1);
    check("s2_press_o", bus.press_o, 8'h01);
    check("s2_any", bus.any_press_o, 1);
    check("s2_level", bus.level_o, 8'h01);
    check("s2_cnt_before", bus.press_cnt_o, 0);
    step();
    check("s2_press_one", bus.press_o, 8'h00);
    check("s2_any_one", bus.any_press_o, 0);
    check("s2_cnt", bus.press_cnt_o, 1);
    bus.btn_i[0] = 1'b1;
    wait_evt(1, 8'h01, 14, n);
    check("s2_rel_lat", (n >= 11 && n <= 14), 1);
    check("s2_rel_o", bus.release_o, 8'h01);
    check("s2_rel_nopress", bus.press_o, 8'h00);
    check("s2_rel_level", bus.level_o, 8'h00);
    step();
    check("s2_rel_one", bus.release_o, 8'h00);
    check("s2_cnt_hold", bus.press_cnt_o, 1);

    // 3. bounce on ch1
    flag = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) bus.btn_i[1] = ~bus.btn_i[1];
      step();
      if (((bus.press_o | bus.release_o) & 8'h02) != 8'h00) flag = 1'b1;
    end
    check("s3_no_bounce_pulse", flag, 0);
    bus.btn_i[1] = 1'b0;
    wait_evt(0, 8'h02, 14, n);
    check("s3_press_lat", (n >= 11 && n <= 14), 1);
    check("s3_press_o", bus.press_o, 8'h02);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.press_o != 8'h00 || bus.release_o != 8'h00) extra++;
    end
    check("s3_single", extra, 0);
    check("s3_cnt", bus.press_cnt_o, 2);

    // 4. simultaneous ch2..5
    bus.btn_i[5:2] = 4'h0;
    wait_evt(0, 8'h3C, 14, n);
    check("s4_lat", (n >= 11 && n <= 14), 1);
    check("s4_press_o", bus.press_o, 8'h3C);
    check("s4_cnt_before", bus.press_cnt_o, 2);
    step();
    check("s4_cnt", bus.press_cnt_o, 6);

    // 5. reset mid-qualification on ch6 (ch1..5 still held)
    bus.btn_i[6] = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("s5_in_rst", {bus.level_o, bus.press_o, bus.release_o, bus.press_cnt_o}, 32'h0);
    end
    rst = 1'b0;
    step();
    check("s5_after_rst", {bus.press_o, bus.release_o}, 16'h0);
    wait_evt(0, 8'h40, 13, n);
    check("s5_lat", (n >= 0 && n + 1 >= 11 && n + 1 <= 14), 1);
    check("s5_press_o", bus.press_o, 8'h7E);
    step();
    check("s5_cnt", bus.press_cnt_o, 6);

    // 6. counter wrap on ch7
    bus.btn_i = 8'hFF;
    for (int i = 0; i < 30; i++) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("s6_cnt_clear", bus.press_cnt_o, 0);
    misses = 0;
    for (int p = 1; p <= 257; p++) begin
      bus.btn_i[7] = 1'b0;
      wait_evt(0, 8'h80, 20, n);
      if (n < 0) misses++;
      step();
      if (p == 255) check("s6_cnt_255", bus.press_cnt_o, 255);
      if (p == 256) check("s6_cnt_256", bus.press_cnt_o, 0);
      if (p == 257) check("s6_cnt_257", bus.press_cnt_o, 1);
      bus.btn_i[7] = 1'b1;
      wait_evt(1, 8'h80, 20, n);
      if (n < 0) misses++;
    end
    check("s6_all_seen", misses, 0);
    step();
    check("s6_cnt_after_rel", bus.press_cnt_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
